// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into make/break key events,
// times out stalled sequences, and tracks held arrow keys as a one-hot direction.
module ps2_key_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iByteValid,
    input  logic [7:0] iByte,
    input  logic       iFrameErr,
    output logic       oKeyEvent,
    output logic [7:0] oKeyCode,
    output logic       oKeyBreak,
    output logic       oKeyExt,
    output logic       oParseErr,
    output logic [3:0] o_direccion
);

    // Counter only has to hold TIMEOUT_CYCLES-1.
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } state_e;

    state_e          r_state, w_state_n;
    logic [CntW-1:0] r_tmo_cnt, w_tmo_cnt_n;
    logic            r_key_event, w_key_event_n;
    logic [7:0]      r_key_code, w_key_code_n;
    logic            r_key_break, w_key_break_n;
    logic            r_key_ext, w_key_ext_n;
    logic            r_parse_err, w_parse_err_n;
    logic [3:0]      r_held, w_held_n;
    logic [3:0]      r_last, w_last_n;
    logic [3:0]      r_dir, w_dir_n;
    logic [3:0]      w_key_dir;

    // Map a decoded scan code to its one-hot direction (0 for non-arrow keys).
    function automatic logic [3:0] dir_of(input logic [7:0] code, input logic ext);
        logic [3:0] d;
        d = 4'b0000;
        if (ext) begin
            case (code)
                8'h6B:   d = 4'b0001;
                8'h72:   d = 4'b0010;
                8'h74:   d = 4'b0100;
                8'h75:   d = 4'b1000;
                default: d = 4'b0000;
            endcase
        end else begin
            case (code)
                8'h1C:   d = 4'b0001;
                8'h1B:   d = 4'b0010;
                8'h23:   d = 4'b0100;
                8'h1D:   d = 4'b1000;
                default: d = 4'b0000;
            endcase
        end
        return d;
    endfunction

    // Fallback ordering when the last-pressed key is gone: up > down > left > right.
    function automatic logic [3:0] prio_of(input logic [3:0] held);
        logic [3:0] d;
        if (held[3])      d = 4'b1000;
        else if (held[1]) d = 4'b0010;
        else if (held[0]) d = 4'b0001;
        else if (held[2]) d = 4'b0100;
        else              d = 4'b0000;
        return d;
    endfunction

    assign w_key_dir = dir_of(w_key_code_n, w_key_ext_n);

    // Next-state: prefix parser, timeout, key events and direction tracking.
    always_comb begin
        w_state_n     = r_state;
        w_tmo_cnt_n   = r_tmo_cnt;
        w_key_event_n = 1'b0;
        w_key_code_n  = r_key_code;
        w_key_break_n = r_key_break;
        w_key_ext_n   = r_key_ext;
        w_parse_err_n = 1'b0;
        w_held_n      = r_held;
        w_last_n      = r_last;

        // A byte in the firing cycle wins over the timeout.
        if (iByteValid || (r_state == StIdle)) begin
            w_tmo_cnt_n = '0;
        end else if (r_tmo_cnt == TmoLast) begin
            w_tmo_cnt_n   = '0;
            w_state_n     = StIdle;
            w_parse_err_n = 1'b1;
        end else begin
            w_tmo_cnt_n = r_tmo_cnt + 1'b1;
        end

        if (iByteValid) begin
            if (iFrameErr) begin
                w_state_n     = StIdle;
                w_parse_err_n = 1'b1;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (iByte == 8'hE0) begin
                            w_state_n = StExt;
                        end else if (iByte == 8'hF0) begin
                            w_state_n = StBrk;
                        end else if ((iByte == 8'hAA) || (iByte == 8'hFC)) begin
                            // Keyboard self-test result: forget everything held.
                            w_held_n = 4'b0000;
                            w_last_n = 4'b0000;
                        end else begin
                            w_key_event_n = 1'b1;
                            w_key_code_n  = iByte;
                            w_key_break_n = 1'b0;
                            w_key_ext_n   = 1'b0;
                        end
                    end
                    StExt: begin
                        if (iByte == 8'hF0) begin
                            w_state_n = StExtBrk;
                        end else if (iByte != 8'hE0) begin
                            w_state_n     = StIdle;
                            w_key_event_n = 1'b1;
                            w_key_code_n  = iByte;
                            w_key_break_n = 1'b0;
                            w_key_ext_n   = 1'b1;
                        end
                    end
                    StBrk, StExtBrk: begin
                        w_state_n = StIdle;
                        if ((iByte == 8'hE0) || (iByte == 8'hF0)) begin
                            w_parse_err_n = 1'b1;
                        end else begin
                            w_key_event_n = 1'b1;
                            w_key_code_n  = iByte;
                            w_key_break_n = 1'b1;
                            w_key_ext_n   = (r_state == StExtBrk);
                        end
                    end
                    default: w_state_n = StIdle;
                endcase
            end
        end

        if (w_key_event_n && (w_key_dir != 4'b0000)) begin
            if (w_key_break_n) begin
                w_held_n = r_held & ~w_key_dir;
            end else begin
                // Typematic repeats of an already-held key keep the old last-pressed.
                if ((r_held & w_key_dir) == 4'b0000) begin
                    w_last_n = w_key_dir;
                end
                w_held_n = r_held | w_key_dir;
            end
        end

        if ((w_last_n & w_held_n) != 4'b0000) begin
            w_dir_n = w_last_n;
        end else begin
            w_dir_n = prio_of(w_held_n);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state     <= StIdle;
            r_tmo_cnt   <= '0;
            r_key_event <= 1'b0;
            r_key_code  <= 8'h00;
            r_key_break <= 1'b0;
            r_key_ext   <= 1'b0;
            r_parse_err <= 1'b0;
            r_held      <= 4'b0000;
            r_last      <= 4'b0000;
            r_dir       <= 4'b0000;
        end else begin
            r_state     <= w_state_n;
            r_tmo_cnt   <= w_tmo_cnt_n;
            r_key_event <= w_key_event_n;
            r_key_code  <= w_key_code_n;
            r_key_break <= w_key_break_n;
            r_key_ext   <= w_key_ext_n;
            r_parse_err <= w_parse_err_n;
            r_held      <= w_held_n;
            r_last      <= w_last_n;
            r_dir       <= w_dir_n;
        end
    end

    assign oKeyEvent   = r_key_event;
    assign oKeyCode    = r_key_code;
    assign oKeyBreak   = r_key_break;
    assign oKeyExt     = r_key_ext;
    assign oParseErr   = r_parse_err;
    assign o_direccion = r_dir;

endmodule

// File: doc/ps2_key_sequencer.md
PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, is the number of Clock cycles without a byte after which a partial sequence is abandoned.
REQ-002 Clock  input  1  system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-low reset, sampled on the rising edge of Clock.
REQ-004 iByteValid  input  1  one-cycle strobe; iByte and iFrameErr are valid in this cycle.
REQ-005 iByte  input  8  received PS2 scan-code byte (start/parity/stop already stripped).
REQ-006 iFrameErr  input  1  parity/stop error flag for the byte strobed in this cycle.
REQ-007 oKeyEvent  output  1  one-cycle pulse when a complete make or break sequence has been decoded.
REQ-008 oKeyCode  output  8  final scan code of the decoded sequence; valid while oKeyEvent=1, held otherwise.
REQ-009 oKeyBreak  output  1  1 = release (F0 seen), 0 = press; qualified by oKeyEvent.
REQ-010 oKeyExt  output  1  1 = E0-prefixed code; qualified by oKeyEvent.
REQ-011 oParseErr  output  1  one-cycle pulse on frame error, illegal prefix, or timeout.
REQ-012 o_direccion  output  4  one-hot direction: bit0 left, bit1 down, bit2 right, bit3 up; 0000 = none.

Function
REQ-013 Parser states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen); bytes are processed only in cycles with iByteValid=1.
REQ-014 IDLE: E0 -> EXT; F0 -> BRK; any other byte -> event (make, non-ext), stay IDLE.
REQ-015 EXT: F0 -> EXT_BRK; E0 -> stay EXT, no error; other -> event (make, ext), go IDLE.
REQ-016 BRK: F0 or E0 -> oParseErr, go IDLE; other -> event (break, non-ext), go IDLE.
REQ-017 EXT_BRK: F0 or E0 -> oParseErr, go IDLE; other -> event (break, ext), go IDLE.
REQ-018 Event outputs and oParseErr are registered: asserted in the cycle after the accepted iByteValid cycle.
REQ-019 Byte with iFrameErr=1: byte discarded, state -> IDLE, oParseErr pulses, held-key map unchanged.
REQ-020 Byte 0xAA or 0xFC accepted in IDLE: no event; held-key map cleared; o_direccion -> 0000 next cycle.
REQ-021 Timeout counter: cleared on every iByteValid and while in IDLE; increments each cycle otherwise; on reaching TIMEOUT_CYCLES-1: state -> IDLE, counter cleared, oParseErr pulses.
REQ-022 iByteValid in the same cycle the timeout would fire: byte is processed, timeout suppressed.
REQ-023 Direction keys: left = 1C or E0 6B; down = 1B or E0 72; right = 23 or E0 74; up = 1D or E0 75.
REQ-024 Held map (4 bits): make of direction key sets its bit; break clears it; non-direction events ignore it.
REQ-025 Last-pressed register records the direction of a make only when that bit was previously clear (typematic repeats do not change it).
REQ-026 o_direccion = last-pressed if still held; else highest-priority held bit (up > down > left > right); else 0000; updated in the cycle the event outputs assert.
REQ-027 Break of a non-held direction key: no change, no error.

Reset
REQ-028 With Reset=0 at a rising edge: state IDLE, timeout counter 0, held map 0, last-pressed none, oKeyEvent=0, oKeyCode=00, oKeyBreak=0, oKeyExt=0, oParseErr=0, o_direccion=0000.
REQ-029 Reset mid-sequence (e.g. in EXT_BRK) discards the partial sequence; bytes strobed while Reset=0 are ignored.

Verification
REQ-030 Bytes 1D; F0 1D -> event make/1D then break/1D; o_direccion 1000 then 0000.
REQ-031 Bytes E0 6B; 1C; F0 1C -> left pressed twice via different codes: o_direccion 0001 after each make; stays 0001 only if another left source held, else 0000 after break (held map is per direction: break clears bit -> 0000).
REQ-032 Bytes 1D, 23, F0 23 -> o_direccion 1000, 0100, 1000 (fallback to held up).
REQ-033 Byte E0 then 50000 idle cycles -> oParseErr pulses once, state IDLE; subsequent 1B -> event make/1B non-ext, o_direccion 0010.
REQ-034 Byte 1B with iFrameErr=1 -> no event, oParseErr pulse, o_direccion unchanged; then F0 F0 -> oParseErr on second F0.
REQ-035 Bytes 23, AA -> o_direccion 0100 then 0000; Reset=0 during E0 F0 then 23 after release -> event make/23, o_direccion 0100.
